// File: rtl/game_pkg.sv
// Shared constants, state encoding and BCD helper for the reaction/memory game.
package game_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;    // 10 ms at 50 MHz
  localparam int DEFAULT_HOLD_CYCLES     = 50000000;  // 1 s at 50 MHz

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_EDIT    = 2'd1;
  localparam state_t ST_CHECK   = 2'd2;
  localparam state_t ST_CHECKED = 2'd3;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchroniser, stability counter and
// a one-cycle press pulse issued on the debounced 1->0 transition.
module key_debounce
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic key_n,
  output logic press
);

  localparam int              CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          settle;

  // The pulse is decoded from the flip condition so the consumer acts on the
  // same edge the debounced level changes.
  assign settle = (sync2_reg != level_reg) && (cnt_reg == CNT_LAST);
  assign press  = settle && level_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
      level_reg <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= key_n;
      sync2_reg <= sync1_reg;
      if (sync2_reg == level_reg) begin
        cnt_reg <= '0;
      end else if (settle) begin
        level_reg <= sync2_reg;
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/answer_entry.sv
// Player answer entry: three debounced keys dial a two-digit BCD answer, which is
// compared with the displayed target on submit and held for a fixed time.
module answer_entry
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEFAULT_HOLD_CYCLES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_inc_n,
  input  logic       key_next_n,
  input  logic       key_submit_n,
  input  logic       active,
  input  logic [3:0] target_ones,
  input  logic [3:0] target_tens,
  output logic [3:0] entry_ones,
  output logic [3:0] entry_tens,
  output logic       digit_sel,
  output logic       result_valid,
  output logic       result_match,
  output logic       busy
);

  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  // Key index: 0 = inc, 1 = next, 2 = submit
  logic [2:0] keys_n;
  logic [2:0] press;

  assign keys_n = {key_submit_n, key_next_n, key_inc_n};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
      key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk   (clk),
        .resetn(resetn),
        .key_n (keys_n[gi]),
        .press (press[gi])
      );
    end
  endgenerate

  logic do_submit;
  logic do_next;
  logic do_inc;

  assign do_submit = press[2];
  assign do_next   = press[1] && !press[2];
  assign do_inc    = press[0] && !press[1] && !press[2];

  state_t        state_reg;
  logic [3:0]    ones_reg;
  logic [3:0]    tens_reg;
  logic          sel_reg;
  logic [3:0]    tgt_ones_reg;
  logic [3:0]    tgt_tens_reg;
  logic          valid_reg;
  logic          match_reg;
  logic [HW-1:0] hold_cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_IDLE;
      ones_reg     <= '0;
      tens_reg     <= '0;
      sel_reg      <= 1'b0;
      tgt_ones_reg <= '0;
      tgt_tens_reg <= '0;
      valid_reg    <= 1'b0;
      match_reg    <= 1'b0;
      hold_cnt_reg <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          ones_reg  <= '0;
          tens_reg  <= '0;
          sel_reg   <= 1'b0;
          match_reg <= 1'b0;
          if (active) state_reg <= ST_EDIT;
        end
        ST_EDIT: begin
          // Losing the round outranks any key event in the same cycle.
          if (!active) begin
            ones_reg  <= '0;
            tens_reg  <= '0;
            sel_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end else if (do_submit) begin
            tgt_ones_reg <= target_ones;
            tgt_tens_reg <= target_tens;
            state_reg    <= ST_CHECK;
          end else if (do_next) begin
            sel_reg <= !sel_reg;
          end else if (do_inc) begin
            if (sel_reg) tens_reg <= bcd_inc(tens_reg);
            else         ones_reg <= bcd_inc(ones_reg);
          end
        end
        ST_CHECK: begin
          match_reg    <= (ones_reg == tgt_ones_reg) && (tens_reg == tgt_tens_reg);
          valid_reg    <= 1'b1;
          hold_cnt_reg <= '0;
          state_reg    <= ST_CHECKED;
        end
        ST_CHECKED: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_reg <= '0;
            ones_reg     <= '0;
            tens_reg     <= '0;
            sel_reg      <= 1'b0;
            match_reg    <= 1'b0;
            state_reg    <= active ? ST_EDIT : ST_IDLE;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign entry_ones   = ones_reg;
  assign entry_tens   = tens_reg;
  assign digit_sel    = sel_reg;
  assign result_valid = valid_reg;
  assign result_match = match_reg;
  assign busy         = (state_reg == ST_CHECKED);

endmodule

// File: tb/tb_answer_entry.sv
// Bench for answer_entry with short debounce/hold times: vector table, directed
// corner sequences and randomized presses against a digit-level reference model.
module tb_answer_entry;

  localparam int DB   = 4;
  localparam int HOLD = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_inc_n, key_next_n, key_submit_n;
  logic       active;
  logic [3:0] target_ones, target_tens;
  logic [3:0] entry_ones, entry_tens;
  logic       digit_sel, result_valid, result_match, busy;

  answer_entry #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .key_inc_n   (key_inc_n),
    .key_next_n  (key_next_n),
    .key_submit_n(key_submit_n),
    .active      (active),
    .target_ones (target_ones),
    .target_tens (target_tens),
    .entry_ones  (entry_ones),
    .entry_tens  (entry_tens),
    .digit_sel   (digit_sel),
    .result_valid(result_valid),
    .result_match(result_match),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: the answer as two decimal digits plus the cursor.
  int m_ones = 0;
  int m_tens = 0;
  int m_sel  = 0;

  typedef struct {
    int         key;  // 0 = inc, 1 = next
    logic [3:0] ones;
    logic [3:0] tens;
    logic       sel;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input int k);
    if (k == 0) key_inc_n = 1'b0;
    else        key_next_n = 1'b0;
    cyc(DB + 4);
    key_inc_n  = 1'b1;
    key_next_n = 1'b1;
    cyc(DB + 4);
  endtask

  task automatic model_press(input int k);
    press_key(k);
    if (k == 0) begin
      if (m_sel == 1) m_tens = (m_tens + 1) % 10;
      else            m_ones = (m_ones + 1) % 10;
    end else begin
      m_sel = 1 - m_sel;
    end
    $display("press %s -> entry %0d%0d sel %0d", (k == 0) ? "inc " : "next",
             entry_tens, entry_ones, digit_sel);
    check("model_entry", {entry_tens, entry_ones, 3'b0, digit_sel},
          {m_tens[3:0], m_ones[3:0], 3'b0, m_sel[0]});
  endtask

  // One full submit/hold round, observed cycle by cycle.
  task automatic submit_round(input logic [3:0] t_ones, input logic [3:0] t_tens,
                              input bit with_inc, input bit inc_in_hold, input bit exp_match);
    int         vcount      = 0;
    int         busy_cycles = 0;
    int         inc_t       = -1;
    logic       m           = 1'b0;
    logic [3:0] ao          = 4'hf;
    logic [3:0] at          = 4'hf;
    target_ones  = t_ones;
    target_tens  = t_tens;
    key_submit_n = 1'b0;
    if (with_inc) key_inc_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      if (i == 9) begin
        key_submit_n = 1'b1;
        if (with_inc) key_inc_n = 1'b1;
      end
      if (result_valid) begin
        vcount++;
        m  = result_match;
        ao = entry_ones;
        at = entry_tens;
      end
      if (busy) begin
        busy_cycles++;
        if (inc_in_hold && inc_t < 0) begin
          key_inc_n = 1'b0;
          inc_t     = i;
        end
      end
      if (inc_t >= 0 && i == inc_t + DB + 4) key_inc_n = 1'b1;
    end
    $display("submit target %0d%0d entry %0d%0d -> valid x%0d match %0d busy %0d",
             t_tens, t_ones, m_tens, m_ones, vcount, m, busy_cycles);
    check("valid_pulses", vcount, 1);
    check("result_match", m, exp_match);
    check("entry_at_result", {at, ao}, {m_tens[3:0], m_ones[3:0]});
    check("busy_cycles", busy_cycles, HOLD);
    check("cleared_after_hold", {entry_tens, entry_ones, digit_sel, result_match, busy}, 0);
    m_ones = 0;
    m_tens = 0;
    m_sel  = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int r;
    logic [3:0] t1, t10;
    bit ok;

    resetn       = 1'b0;
    key_inc_n    = 1'b1;
    key_next_n   = 1'b1;
    key_submit_n = 1'b1;
    active       = 1'b0;
    target_ones  = 4'd0;
    target_tens  = 4'd0;
    cyc(3);
    check("reset_outputs", {entry_tens, entry_ones, digit_sel, result_valid, result_match, busy}, 0);
    resetn = 1'b1;
    cyc(2);
    active = 1'b1;
    cyc(2);

    // Press latency from raw edge to the digit change
    key_inc_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      if (lat < 0 && entry_ones == 4'd1) lat = i;
    end
    key_inc_n = 1'b1;
    cyc(DB + 4);
    $display("latency press -> entry_ones %0d after %0d cycles", entry_ones, lat);
    check("press_latency", lat, 2 + DB);
    check("single_inc", entry_ones, 1);

    // Short glitch
    key_inc_n = 1'b0;
    cyc(2);
    key_inc_n = 1'b1;
    cyc(DB + 6);
    $display("glitch 2 cycles -> entry_ones %0d", entry_ones);
    check("glitch_ignored", entry_ones, 1);

    // Round ends while editing
    active = 1'b0;
    cyc(1);
    check("active_drop_clear", {entry_tens, entry_ones, digit_sel}, 0);
    cyc(2);
    check("idle_stays_clear", {entry_tens, entry_ones, digit_sel, busy}, 0);
    active = 1'b1;
    cyc(2);

    for (int i = 0; i < 10; i++) tbl[i] = '{0, 4'((i + 1) % 10), 4'd0, 1'b0};
    tbl[10] = '{1, 4'd0, 4'd0, 1'b1};
    for (int i = 0; i < 3; i++) tbl[11 + i] = '{0, 4'd0, 4'(i + 1), 1'b1};
    tbl[14] = '{1, 4'd0, 4'd3, 1'b0};
    for (int i = 0; i < 7; i++) tbl[15 + i] = '{0, 4'(i + 1), 4'd3, 1'b0};

    for (int i = 0; i < 22; i++) begin
      press_key(tbl[i].key);
      $display("vec %0d key %0d -> entry %0d%0d sel %0d", i, tbl[i].key,
               entry_tens, entry_ones, digit_sel);
      check($sformatf("vec%0d", i), {entry_tens, entry_ones, 3'b0, digit_sel},
            {tbl[i].tens, tbl[i].ones, 3'b0, tbl[i].sel});
    end
    m_ones = 7;
    m_tens = 3;
    m_sel  = 0;

    submit_round(4'd7, 4'd3, 0, 0, 1'b1);

    model_press(1);
    for (int i = 0; i < 3; i++) model_press(0);
    model_press(1);
    for (int i = 0; i < 7; i++) model_press(0);
    submit_round(4'd6, 4'd3, 0, 0, 1'b0);

    // Submit and inc debounce together: inc must be dropped
    model_press(0);
    submit_round(4'd1, 4'd0, 1, 0, 1'b1);

    // Inc during the hold is ignored
    model_press(0);
    model_press(0);
    submit_round(4'd9, 4'd9, 0, 1, 1'b0);
    cyc(4);
    check("inc_in_hold_ignored", {entry_tens, entry_ones}, 0);

    // Randomized presses against the model
    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        model_press(0);
      end else if (r < 8) begin
        model_press(1);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          t1  = m_ones[3:0];
          t10 = m_tens[3:0];
        end else begin
          t1  = 4'($urandom_range(0, 15));
          t10 = 4'($urandom_range(0, 15));
        end
        submit_round(t1, t10, 0, 0, (int'(t1) == m_ones) && (int'(t10) == m_tens));
      end
    end

    // Reset in the middle of the hold
    model_press(0);
    key_submit_n = 1'b1;
    target_ones  = 4'($urandom_range(0, 9));
    key_submit_n = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      cyc(1);
      if (busy) ok = 1'b1;
    end
    check("hold_reached", ok, 1'b1);
    cyc(2);
    resetn = 1'b0;
    #1;
    $display("reset mid-hold -> outputs %0h", {entry_tens, entry_ones, digit_sel, result_valid, result_match, busy});
    check("async_reset_outputs", {entry_tens, entry_ones, digit_sel, result_valid, result_match, busy}, 0);
    key_submit_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      if (result_valid || busy) ok = 1'b1;
    end
    check("no_result_in_reset", ok, 1'b0);
    resetn = 1'b1;
    m_ones = 0;
    m_tens = 0;
    m_sel  = 0;
    cyc(3);
    model_press(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/answer_entry.md
Name: answer_entry

Overview:
- Player-input side of the reaction/memory game: the input direction matching the game's timer/LFSR-to-hex display path.
- Debounces three active-low pushbuttons and lets the player dial a two-digit BCD answer (ones, tens).
- On submit, compares the answer against the displayed target and emits a one-cycle result pulse.
- Holds the entry and result for a fixed time, then clears for the next round.
- Entry digits feed the existing hex decoders; the result feeds score logic.

Parameters:
DEBOUNCE_CYCLES, 500000, cycles a raw key must be stable before it is accepted (10 ms at 50 MHz)
HOLD_CYCLES, 50000000, cycles the CHECKED state holds entry/result before auto-clear (1 s)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
resetn  in  1  asynchronous active-low reset
key_inc_n  in  1  raw pushbutton, active-low: increment selected digit
key_next_n  in  1  raw pushbutton, active-low: toggle selected digit ones/tens
key_submit_n  in  1  raw pushbutton, active-low: submit answer
active  in  1  game round running; entry accepted only when high
target_ones  in  4  BCD target ones digit, sampled on submit
target_tens  in  4  BCD target tens digit, sampled on submit
entry_ones  out  4  current ones digit, 0-9
entry_tens  out  4  current tens digit, 0-9
digit_sel  out  1  0 = ones selected, 1 = tens selected
result_valid  out  1  one-cycle pulse when the comparison completes
result_match  out  1  1 if entry equals target; held until the next clear
busy  out  1  high in CHECKED (input locked)

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, debounce counters 0, debounced levels = released (1).
- Debounce, per key:
  - 2-flop synchroniser, then a counter.
  - If the synced level differs from the debounced level, count up; otherwise counter = 0.
  - When the count reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Press event = one-cycle pulse on debounced 1->0. No event on release.
  - Total press latency = 2 + DEBOUNCE_CYCLES cycles after the raw edge. Glitches shorter than DEBOUNCE_CYCLES produce no event.
- Same-cycle press priority: submit > next > inc. Lower-priority events in that cycle are dropped.
- FSM states: IDLE, EDIT, CHECK, CHECKED.
  - IDLE:
    - Outputs cleared, events ignored.
    - active=1 -> EDIT with digit_sel=0.
  - EDIT:
    - inc: selected digit +1; 9 wraps to 0; other digit unchanged.
    - next: digit_sel toggles.
    - submit: capture target_ones/target_tens -> CHECK.
    - active=0: clear entry -> IDLE.
  - CHECK (1 cycle):
    - result_match <= entry == captured target (both digits).
    - result_valid pulses high this cycle.
    - -> CHECKED.
  - CHECKED:
    - busy=1; all key events ignored; hold counter runs 0..HOLD_CYCLES-1.
    - On terminal count: clear entry, digit_sel, result_match; go to EDIT if active=1, else IDLE.
    - active falling does not abort the hold.
- Width rules:
  - Digits are 4-bit, always 0-9.
  - Counters are sized with $clog2 of their parameter.
  - Targets >9 on input are compared bitwise and never match a legal entry.
- Reset mid-debounce or mid-hold: immediate return to reset values; no result pulse.

Decomposition:
- Shared package (game_pkg):
  - FSM state enum (IDLE, EDIT, CHECK, CHECKED).
  - BCD_MAX = 4'd9.
  - Default timing constants, shared with the existing one-second enable.
- One sub-module: key_debounce (synchroniser + stable counter + press pulse), parameter DEBOUNCE_CYCLES, instantiated three times.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=8):
- Hold key_inc_n low 10 cycles, active=1 -> entry_ones 0->1 exactly 6 cycles after the edge; a 2-cycle low glitch -> no change.
- 10 inc presses -> entry_ones 1,2,...,9,0; entry_tens stays 0.
- next, then 3 inc, then next, then 7 inc -> entry_tens=3, entry_ones=7, digit_sel=0.
- Entry 37, target 3/7, submit -> result_valid one cycle, result_match=1, busy 8 cycles, then entry 00 and EDIT; with target 3/6 -> result_match=0.
- submit and inc debounced in the same cycle -> CHECK entered, digit unchanged; inc during CHECKED -> ignored.
- active drop in EDIT -> IDLE, entry 00; resetn low mid-hold -> all outputs 0 immediately, no result_valid.
